stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
Timekeeping datapath driven by the stopwatch control FSM's 2-bit `en` code. It consumes `en` as follows:
- 00: clear
- 01: count up
- 10: pause
A clock prescaler generates centisecond ticks, which advance a cascaded BCD time value (MM:SS.cc) for the 7-segment display driver.

Parameters:
- CLK_FREQ_HZ, 100000000, input clock frequency.
- TICK_HZ, 100, count resolution (centiseconds). DIV = CLK_FREQ_HZ/TICK_HZ must be an integer >= 1.
- PRE_W, 20, prescaler width. Must satisfy 2^PRE_W >= DIV.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  2  control code from the stopwatch FSM (00 clear, 01 run, 10 pause, 11 illegal).
- cs_ones  output  4  BCD centiseconds, ones.
- cs_tens  output  4  BCD centiseconds, tens.
- s_ones  output  4  BCD seconds, ones.
- s_tens  output  4  BCD seconds, tens (0-5).
- m_ones  output  4  BCD minutes, ones.
- m_tens  output  4  BCD minutes, tens (0-5).
- tick  output  1  one-cycle pulse on each cycle the count advances.
- running  output  1  high while the registered mode is RUN.
- overflow  output  1  sticky; set on rollover past 59:59.99.

Behaviour:
- Reset (reset=0, async): prescaler=0, all digits=0, tick=0, running=0, overflow=0, mode=CLEAR. Takes effect immediately, without a clock edge. Reset mid-run discards all state.
- `en` is sampled on every rising edge; there is no synchronizer (the FSM shares clk).
- Mode register (3 states), set from `en` each edge:
  - CLEAR (en=00): prescaler, digits and overflow forced to 0; tick=0; running=0.
  - RUN (en=01): running=1; prescaler increments each cycle.
  - HOLD (en=10 or 11): prescaler and digits frozen; tick=0; running=0.
  - en=11 is always treated as HOLD.
- Terminal count in RUN: when prescaler==DIV-1 on an edge with en=01:
  - prescaler wraps to 0;
  - digits advance by one centisecond on that same edge;
  - tick=1 for exactly that cycle (registered together with the digits).
  - Count latency: the first increment occurs on the DIV-th consecutive run edge after CLEAR.
- Pause/resume: HOLD->RUN resumes from the held prescaler value, so total run cycles per increment stay exactly DIV. RUN->CLEAR zeroes everything on the same edge.
- BCD cascade, each digit wrapping with a carry to the next:
  - cs_ones 9->0, carry into cs_tens;
  - cs_tens 9->0, carry into s_ones;
  - s_ones 9->0, carry into s_tens;
  - s_tens 5->0, carry into m_ones;
  - m_ones 9->0, carry into m_tens;
  - m_tens 5->0, which is the rollover.
- Rollover: 59:59.99 + 1 tick gives 00:00.00 and sets overflow=1. Overflow holds until CLEAR or reset; counting continues after rollover.
- DIV=1: tick every run cycle, prescaler constantly 0.
- Outputs are registered; no combinational path from en to any output.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - Adds input `lap` (1 bit, sampled, rising-edge detected internally) and output `lap_hold` (1 bit, reset 0).
  - A lap rising edge in RUN copies the live digits into a display snapshot and sets lap_hold=1.
  - While lap_hold=1, the digit outputs show the snapshot, and the live count continues internally.
  - The next lap rising edge clears lap_hold; the outputs return to the live value on the following cycle.
  - A lap edge in HOLD or CLEAR is ignored.
  - CLEAR or reset clears lap_hold and the snapshot.
  - tick and overflow always reflect the live count.
- Not defined: no `lap` or `lap_hold` ports; digit outputs are the live count directly.

Test Plan:
- Reset and first tick (CLK_FREQ_HZ=1000, TICK_HZ=100, DIV=10): reset low then high, en=01 for 10 edges.
  - Required: cs_ones=1 after the 10th edge, tick high exactly once, running=1.
- Seconds carry (same DIV): run 1000 cycles.
  - Required: s_ones=1, cs_tens=0, cs_ones=0, tick seen 100 times.
- Pause accuracy: run 4 edges, then en=10 for 37 edges, then en=01 for 6 edges.
  - Required: cs_ones=1 on exactly the 6th resumed edge.
  - Required: digits unchanged and tick=0 throughout the pause.
  - Repeat the pause with en=11: identical result.
- Rollover (DIV=1): run 359999 cycles.
  - Required: 59:59.99, overflow=0.
  - One more cycle: 00:00.00, overflow=1, tick=1.
  - en=00 for one edge: overflow=0.
- Async reset mid-run: at count 00:03.47, pull reset low between clock edges.
  - Required: all outputs 0 before the next edge; they stay 0 while reset=0.
- Lap (STOPWATCH_LAP_EN, DIV=10):
  - Lap pulse at 00:00.05, then run 50 more cycles: outputs hold 00:00.05, lap_hold=1.
  - Second lap pulse: outputs show 00:00.10 one cycle later, lap_hold=0.

Source files
------------

// File: rtl/stopwatch_counter.sv
// Centisecond stopwatch datapath: prescaler plus cascaded BCD MM:SS.cc count, driven by a 2-bit mode code.
// Optional lap/split display snapshot when STOPWATCH_LAP_EN is defined.
module stopwatch_counter #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int TICK_HZ     = 100,
    parameter int PRE_W       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] en,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
`endif
    output logic [3:0] cs_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] s_ones,
    output logic [3:0] s_tens,
    output logic [3:0] m_ones,
    output logic [3:0] m_tens,
    output logic       tick,
    output logic       running,
    output logic       overflow
`ifdef STOPWATCH_LAP_EN
    ,
    output logic       lap_hold
`endif
);

    localparam int               DIV      = CLK_FREQ_HZ / TICK_HZ;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    // Wrap value per digit, least significant (cs_ones) in the low nibble.
    localparam logic [23:0]      DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    typedef enum logic [1:0] {
        MODE_CLEAR = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_HOLD  = 2'd2
    } mode_t;

    mode_t            mode;
    logic [PRE_W-1:0] pre;
    logic [23:0]      live;
    logic [24:0]      live_inc;
    logic [23:0]      disp;

    // Returns {rollover_carry, next_digits}.
    function automatic logic [24:0] bcd_inc(input logic [23:0] d);
        logic [23:0] n;
        logic        c;
        n = d;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (c) begin
                if (d[i*4 +: 4] == DIGIT_MAX[i*4 +: 4]) begin
                    n[i*4 +: 4] = 4'd0;
                end else begin
                    n[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, n};
    endfunction

    assign live_inc = bcd_inc(live);
    assign running  = (mode == MODE_RUN);

`ifdef STOPWATCH_LAP_EN
    logic        lap_q;
    logic [23:0] snap;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode     <= MODE_CLEAR;
            pre      <= '0;
            live     <= '0;
            tick     <= 1'b0;
            overflow <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_q    <= 1'b0;
            lap_hold <= 1'b0;
            snap     <= '0;
`endif
        end else begin
            tick <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_q <= lap;
`endif
            case (en)
                2'b00: begin
                    mode     <= MODE_CLEAR;
                    pre      <= '0;
                    live     <= '0;
                    overflow <= 1'b0;
`ifdef STOPWATCH_LAP_EN
                    lap_hold <= 1'b0;
                    snap     <= '0;
`endif
                end
                2'b01: begin
                    mode <= MODE_RUN;
                    if (pre == PRE_LAST) begin
                        pre  <= '0;
                        live <= live_inc[23:0];
                        tick <= 1'b1;
                        if (live_inc[24]) overflow <= 1'b1;
                    end else begin
                        pre <= pre + 1'b1;
                    end
`ifdef STOPWATCH_LAP_EN
                    // Snapshot takes the pre-edge live value, i.e. what the display shows now.
                    if (lap && !lap_q) begin
                        if (lap_hold) begin
                            lap_hold <= 1'b0;
                        end else begin
                            snap     <= live;
                            lap_hold <= 1'b1;
                        end
                    end
`endif
                end
                default: mode <= MODE_HOLD;
            endcase
        end
    end

`ifdef STOPWATCH_LAP_EN
    assign disp = lap_hold ? snap : live;
`else
    assign disp = live;
`endif

    assign {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones} = disp;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: a DIV=10 instance for count/pause/reset/lap, a DIV=1 instance for rollover.
module tb_stopwatch_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [1:0] en_a, en_b;
    wire  [23:0] dig_a, dig_b;
    wire        tick_a, run_a, ovf_a;
    wire        tick_b, run_b, ovf_b;
`ifdef STOPWATCH_LAP_EN
    logic lap_a, lap_b;
    wire  lap_hold_a, lap_hold_b;
`endif

    stopwatch_counter #(.CLK_FREQ_HZ(1000), .TICK_HZ(100), .PRE_W(4)) u_dut_a (
        .clk(clk), .reset(rst_a), .en(en_a),
`ifdef STOPWATCH_LAP_EN
        .lap(lap_a),
`endif
        .cs_ones(dig_a[3:0]), .cs_tens(dig_a[7:4]), .s_ones(dig_a[11:8]),
        .s_tens(dig_a[15:12]), .m_ones(dig_a[19:16]), .m_tens(dig_a[23:20]),
        .tick(tick_a), .running(run_a), .overflow(ovf_a)
`ifdef STOPWATCH_LAP_EN
        , .lap_hold(lap_hold_a)
`endif
    );

    stopwatch_counter #(.CLK_FREQ_HZ(100), .TICK_HZ(100), .PRE_W(1)) u_dut_b (
        .clk(clk), .reset(rst_b), .en(en_b),
`ifdef STOPWATCH_LAP_EN
        .lap(lap_b),
`endif
        .cs_ones(dig_b[3:0]), .cs_tens(dig_b[7:4]), .s_ones(dig_b[11:8]),
        .s_tens(dig_b[15:12]), .m_ones(dig_b[19:16]), .m_tens(dig_b[23:20]),
        .tick(tick_b), .running(run_b), .overflow(ovf_b)
`ifdef STOPWATCH_LAP_EN
        , .lap_hold(lap_hold_b)
`endif
    );

    int total = 0;
    int bad   = 0;
    int tick_a_cnt = 0;
    int tick_b_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (tick_a) tick_a_cnt++;
            if (tick_b) tick_b_cnt++;
        end
    endtask

    // Hold for n edges while checking digits stay at exp and tick stays low.
    task automatic pause_run(input logic [1:0] code, input int n, input logic [23:0] exp, output int viol);
        viol = 0;
        en_a = code;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (dig_a !== exp || tick_a !== 1'b0 || run_a !== 1'b0) viol++;
        end
    endtask

    task automatic pause_case(input logic [1:0] code, input string tag);
        int viol;
        en_a = 2'b00;
        step(1);
        en_a = 2'b01;
        step(4);
        pause_run(code, 37, 24'h000000, viol);
        check_val({tag, "_pause_viol"}, viol, 0);
        en_a = 2'b01;
        step(5);
        check_val({tag, "_resume5"}, dig_a, 24'h000000);
        step(1);
        check_val({tag, "_resume6"}, dig_a, 24'h000001);
        check_val({tag, "_resume6_tick"}, tick_a, 1'b1);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        en_a = 2'b00; en_b = 2'b00;
`ifdef STOPWATCH_LAP_EN
        lap_a = 1'b0; lap_b = 1'b0;
`endif
        step(3);
        check_val("rst_digits", dig_a, 24'h0);
        check_val("rst_flags", {tick_a, run_a, ovf_a}, 3'b000);
        rst_a = 1'b1; rst_b = 1'b1;

        // First tick on the 10th run edge.
        en_a = 2'b01;
        tick_a_cnt = 0;
        step(9);
        check_val("first_9", dig_a, 24'h000000);
        step(1);
        check_val("first_10", dig_a, 24'h000001);
        check_val("first_tick", tick_a, 1'b1);
        check_val("first_running", run_a, 1'b1);
        check_val("first_tick_cnt", tick_a_cnt, 1);
        step(1);
        check_val("tick_one_cycle", tick_a, 1'b0);

        // Seconds carry.
        en_a = 2'b00;
        step(1);
        check_val("clear_digits", dig_a, 24'h0);
        check_val("clear_running", run_a, 1'b0);
        en_a = 2'b01;
        tick_a_cnt = 0;
        step(1000);
        check_val("sec_carry", dig_a, 24'h000100);
        check_val("sec_tick_cnt", tick_a_cnt, 100);

        pause_case(2'b10, "pause10");
        pause_case(2'b11, "pause11");

        // Async reset mid-run at 00:03.47.
        en_a = 2'b00;
        step(1);
        en_a = 2'b01;
        step(3470);
        check_val("pre_reset_count", dig_a, 24'h000347);
        #3 rst_a = 1'b0;
        #1;
        check_val("async_rst_digits", dig_a, 24'h0);
        check_val("async_rst_flags", {tick_a, run_a, ovf_a}, 3'b000);
        step(2);
        check_val("held_rst_digits", dig_a, 24'h0);
        check_val("held_rst_running", run_a, 1'b0);
        rst_a = 1'b1;
        en_a = 2'b00;
        step(1);

`ifdef STOPWATCH_LAP_EN
        en_a = 2'b01;
        step(50);
        check_val("lap_pre", dig_a, 24'h000005);
        lap_a = 1'b1;
        step(1);
        lap_a = 1'b0;
        check_val("lap_hold_set", lap_hold_a, 1'b1);
        check_val("lap_snap", dig_a, 24'h000005);
        tick_a_cnt = 0;
        step(50);
        check_val("lap_frozen", dig_a, 24'h000005);
        check_val("lap_hold_still", lap_hold_a, 1'b1);
        check_val("lap_live_ticks", tick_a_cnt, 5);
        lap_a = 1'b1;
        step(1);
        lap_a = 1'b0;
        check_val("lap_release", dig_a, 24'h000010);
        check_val("lap_hold_clr", lap_hold_a, 1'b0);
        en_a = 2'b10;
        lap_a = 1'b1;
        step(1);
        lap_a = 1'b0;
        step(1);
        check_val("lap_in_hold_ignored", lap_hold_a, 1'b0);
        check_val("lap_in_hold_digits", dig_a, 24'h000010);
        en_a = 2'b00;
        step(1);
`endif

        // Rollover with DIV=1.
        en_b = 2'b01;
        tick_b_cnt = 0;
        step(1);
        check_val("div1_first", dig_b, 24'h000001);
        check_val("div1_tick", tick_b, 1'b1);
        step(5999);
        check_val("div1_minute", dig_b, 24'h010000);
        check_val("div1_tick_cnt", tick_b_cnt, 6000);
        step(359999 - 6000);
        check_val("roll_max", dig_b, 24'h595999);
        check_val("roll_max_ovf", ovf_b, 1'b0);
        step(1);
        check_val("roll_wrap", dig_b, 24'h000000);
        check_val("roll_ovf", ovf_b, 1'b1);
        check_val("roll_tick", tick_b, 1'b1);
        step(1);
        check_val("roll_continue", dig_b, 24'h000001);
        check_val("roll_ovf_sticky", ovf_b, 1'b1);
        en_b = 2'b00;
        step(1);
        check_val("roll_clear_ovf", ovf_b, 1'b0);
        check_val("roll_clear_digits", dig_b, 24'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
